// File: rtl/channel_layout_ctrl.sv
// channel_layout_ctrl: splits the visible rows of a frame evenly among the enabled channels
// Ports: clk, rst_n (async, active-low); channel_enable requested per-channel enables;
//   frame_start / row_advance row-timing pulses; busy / layout_valid layout computation status;
//   channel_count / channel_height active layout; is_channel / channel_number registered
//   mapping of the current row.
module channel_layout_ctrl #(
  parameter int MAX_CHAN_COUNT = 10,
  parameter int OFFSET = 0,
  parameter int VER_RES = 480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [MAX_CHAN_COUNT-1:0] channel_enable,
  input  logic frame_start,
  input  logic row_advance,
  output logic busy,
  output logic layout_valid,
  output logic [$clog2(MAX_CHAN_COUNT):0] channel_count,
  output logic [$clog2(VER_RES)-1:0] channel_height,
  output logic is_channel,
  output logic [$clog2(MAX_CHAN_COUNT)-1:0] channel_number
);
  localparam int W = $clog2(VER_RES);
  localparam int CW = $clog2(MAX_CHAN_COUNT) + 1;
  localparam int NW = $clog2(MAX_CHAN_COUNT);
  localparam int DW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, COUNT, DIV, READY} state_t;
  state_t state, state_n;
  logic [MAX_CHAN_COUNT-1:0] act_en;
  logic [CW-1:0] pop, rem, vis, vis_n;
  logic [CW:0] rem_sh;
  logic [DW-1:0] step;
  logic [W-1:0] row, row_n, sub, sub_n;
  logic in_area, in_area_n, frame_ok, frame_ok_n, recompute, wrap, qbit;
  logic [NW-1:0] ch_n;
  function automatic logic [NW-1:0] first_set(input logic [MAX_CHAN_COUNT-1:0] en, input int lo);
    first_set = '0;
    for (int i = MAX_CHAN_COUNT - 1; i >= 0; i--)
      if (en[i] && i >= lo) first_set = NW'(i);
  endfunction
  always_comb begin
    pop = '0;
    for (int i = 0; i < MAX_CHAN_COUNT; i++) pop = pop + CW'(act_en[i]);
  end
  assign recompute = frame_start && (channel_enable != act_en || !layout_valid);
  // channel_height doubles as the dividend/quotient shift register during DIV
  assign rem_sh = {rem, channel_height[W-1]};
  assign qbit = rem_sh >= {1'b0, channel_count};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (recompute) state_n = COUNT;
    else if (state == COUNT) state_n = pop == '0 ? READY : DIV;
    else if (state == DIV && step == DW'(W - 1)) state_n = READY;
  end
  always_comb begin
    busy = state == COUNT || state == DIV;
    layout_valid = state == READY;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act_en <= '0;
      channel_count <= '0;
      channel_height <= '0;
      rem <= '0;
      step <= '0;
    end else begin
      if (frame_start) act_en <= channel_enable;
      if (state == COUNT) begin
        channel_count <= pop;
        channel_height <= pop == '0 ? '0 : W'(VER_RES - OFFSET);
        rem <= '0;
        step <= '0;
      end else if (state == DIV) begin
        channel_height <= {channel_height[W-2:0], qbit};
        rem <= qbit ? CW'(rem_sh - {1'b0, channel_count}) : rem_sh[CW-1:0];
        step <= step + 1'b1;
      end
    end
  // wrap is gated by vis so the remainder rows at the bottom never alias back onto a channel
  always_comb begin
    wrap = in_area && sub == channel_height - 1'b1 && vis < channel_count;
    row_n = frame_start ? '0 : row_advance ? row + 1'b1 : row;
    in_area_n = frame_start ? OFFSET == 0 : in_area || (row_advance && row + 1'b1 == W'(OFFSET));
    sub_n = frame_start ? '0 : !(row_advance && in_area) ? sub : wrap ? '0 : sub + 1'b1;
    vis_n = frame_start ? '0 : row_advance && wrap ? vis + 1'b1 : vis;
    ch_n = frame_start ? first_set(channel_enable, 0) :
           row_advance && wrap ? first_set(act_en, int'(channel_number) + 1) : channel_number;
    frame_ok_n = frame_start ? layout_valid && !recompute : frame_ok;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row <= '0;
      sub <= '0;
      vis <= '0;
      in_area <= 1'b0;
      frame_ok <= 1'b0;
      is_channel <= 1'b0;
      channel_number <= '0;
    end else begin
      row <= row_n;
      sub <= sub_n;
      vis <= vis_n;
      in_area <= in_area_n;
      frame_ok <= frame_ok_n;
      is_channel <= frame_ok_n && channel_count != '0 && in_area_n && vis_n < channel_count;
      channel_number <= ch_n;
    end
endmodule

// File: tb/tb_channel_layout_ctrl.sv
// tb_channel_layout_ctrl: checks layout computation and row-to-channel mapping
// for a default instance (OFFSET=0) and an OFFSET=32 instance driven in parallel.
module tb_channel_layout_ctrl;
  localparam int MAXC = 10;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [MAXC-1:0] channel_enable = '0;
  logic frame_start = 1'b0, row_advance = 1'b0;
  logic [1:0] busy, lv, is_ch;
  logic [1:0][4:0] cnt;
  logic [1:0][8:0] ht;
  logic [1:0][3:0] chn;
  int total = 0, bad = 0;
  typedef struct {logic [MAXC-1:0] en; int cnt; int h0; int h1;} vec_t;
  typedef struct {int dut; int ch;} exp_t;
  vec_t vt[6];
  exp_t sb[$];
  channel_layout_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .channel_enable(channel_enable), .frame_start(frame_start),
    .row_advance(row_advance), .busy(busy[0]), .layout_valid(lv[0]), .channel_count(cnt[0]),
    .channel_height(ht[0]), .is_channel(is_ch[0]), .channel_number(chn[0])
  );
  channel_layout_ctrl #(.OFFSET(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .channel_enable(channel_enable), .frame_start(frame_start),
    .row_advance(row_advance), .busy(busy[1]), .layout_valid(lv[1]), .channel_count(cnt[1]),
    .channel_height(ht[1]), .is_channel(is_ch[1]), .channel_number(chn[1])
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int popc(input logic [MAXC-1:0] en);
    int n = 0;
    for (int i = 0; i < MAXC; i++) n += int'(en[i]);
    return n;
  endfunction
  function automatic int kth_bit(input logic [MAXC-1:0] en, input int k);
    int left = k;
    for (int i = 0; i < MAXC; i++)
      if (en[i]) begin
        if (left == 0) return i;
        left--;
      end
    return -1;
  endfunction
  function automatic int exp_ch(input int off, input logic [MAXC-1:0] en, input int r);
    int n = popc(en);
    int h, k;
    if (n == 0 || r < off) return -1;
    h = (480 - off) / n;
    k = (r - off) / h;
    return k >= n ? -1 : kth_bit(en, k);
  endfunction
  task automatic compute(input logic [MAXC-1:0] en, input int ecnt, input int eh0, input int eh1);
    int n;
    channel_enable = en;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    n = 1;
    check($sformatf("busy after start en=%b", en), int'(busy[0]), 1);
    while (!lv[0] && n < 40) begin
      tick;
      n++;
    end
    check($sformatf("latency en=%b", en), n, ecnt == 0 ? 2 : 11);
    check("dut1 layout_valid", int'(lv[1]), 1);
    check($sformatf("count en=%b", en), int'(cnt[0]), ecnt);
    check($sformatf("dut1 count en=%b", en), int'(cnt[1]), ecnt);
    check($sformatf("height en=%b", en), int'(ht[0]), eh0);
    check($sformatf("dut1 height en=%b", en), int'(ht[1]), eh1);
    check("busy when ready", int'(busy[0]), 0);
  endtask
  task automatic walk(input logic [MAXC-1:0] en, input int first, input int last, input bit fs);
    exp_t e;
    for (int r = first; r <= last; r++) begin
      frame_start = fs && r == first;
      row_advance = 1'b1;
      for (int d = 0; d < 2; d++) sb.push_back('{d, exp_ch(d == 1 ? 32 : 0, en, r)});
      tick;
      if (fs && r == first) begin
        check("no recompute busy", int'(busy[0]), 0);
        check("no recompute layout_valid", int'(lv[0]), 1);
      end
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("d%0d row%0d is_channel", e.dut, r), int'(is_ch[e.dut]), int'(e.ch >= 0));
        if (e.ch >= 0)
          check($sformatf("d%0d row%0d channel_number", e.dut, r), int'(chn[e.dut]), e.ch);
      end
    end
    frame_start = 1'b0;
    row_advance = 1'b0;
  endtask
  initial begin
    vt[0] = '{10'b0000100101, 3, 160, 149};
    vt[1] = '{10'h07F, 7, 68, 64};
    vt[2] = '{10'h000, 0, 0, 0};
    vt[3] = '{10'h003, 2, 240, 224};
    vt[4] = '{10'h3FF, 10, 48, 44};
    vt[5] = '{10'h200, 1, 480, 448};
    channel_enable = 10'h3FF;
    tick;
    tick;
    check("reset busy", int'(busy[0]), 0);
    check("reset layout_valid", int'(lv[0]), 0);
    check("reset count", int'(cnt[0]), 0);
    check("reset height", int'(ht[0]), 0);
    check("reset is_channel", int'(is_ch[0]), 0);
    check("reset channel_number", int'(chn[0]), 0);
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 6; i++) begin
      compute(vt[i].en, vt[i].cnt, vt[i].h0, vt[i].h1);
      walk(vt[i].en, 0, 479, 1'b1);
    end
    // enables changed mid-frame must not disturb the running frame
    compute(10'b0000100101, 3, 160, 149);
    walk(10'b0000100101, 0, 199, 1'b1);
    channel_enable = 10'h07F;
    walk(10'b0000100101, 200, 479, 1'b0);
    check("mid-frame count", int'(cnt[0]), 3);
    check("mid-frame height", int'(ht[0]), 160);
    check("mid-frame layout_valid", int'(lv[0]), 1);
    check("mid-frame busy", int'(busy[0]), 0);
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    check("changed enables busy", int'(busy[0]), 1);
    check("changed enables layout_valid", int'(lv[0]), 0);
    tick;
    tick;
    tick;
    // frame_start in DIV restarts with the new enables
    compute(10'h003, 2, 240, 224);
    row_advance = 1'b1;
    tick;
    row_advance = 1'b0;
    check("recompute frame is_channel", int'(is_ch[0]), 0);
    // asynchronous reset while dividing
    channel_enable = 10'b0001111000;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    repeat (4) tick;
    check("pre-reset busy", int'(busy[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy", int'(busy[0]), 0);
    check("async reset layout_valid", int'(lv[0]), 0);
    check("async reset count", int'(cnt[0]), 0);
    check("async reset height", int'(ht[0]), 0);
    check("async reset is_channel", int'(is_ch[0]), 0);
    check("async reset channel_number", int'(chn[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check($sformatf("post-reset layout_valid c%0d", i), int'(lv[0]), 0);
    end
    compute(10'b0001111000, 4, 120, 112);
    walk(10'b0001111000, 0, 479, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
